// File: rtl/datapath_exec_pkg.sv
// Shared constants for the datapath executor: field widths, opcodes, FSM states
// and helpers for slicing food coordinates out of a world-memory address.
package datapath_exec_pkg;

    localparam int OPCODE_W = 4;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int RESULT_W = 16;

    localparam int OP_NOP      = 0;
    localparam int OP_MEMREAD  = 1;
    localparam int OP_MEMWRITE = 2;
    localparam int OP_MEMCLEAR = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_READ_WAIT,
        S_CLEAR,
        S_DONE
    } state_t;

    // World addresses are {y, x}: upper half of the address field is Y, lower half X.
    function automatic logic [ADDR_W/2-1:0] addr_food_x(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W/2-1:0];
    endfunction

    function automatic logic [ADDR_W-ADDR_W/2-1:0] addr_food_y(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ADDR_W/2];
    endfunction

endpackage

// File: rtl/datapath_exec_ram.sv
// Simple dual-port world memory: port A read/write, port B read-only for the
// renderer; both reads are registered and read-before-write. No reset.
module dp_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/datapath_exec.sv
// Instruction executor: runs one {data, addr, opcode} instruction per
// start/finished handshake against world memory and reports a result word.
module datapath_exec
    import datapath_exec_pkg::*;
#(
    parameter int OPCODE_WIDTH      = OPCODE_W,
    parameter int ADDR_WIDTH        = ADDR_W,
    parameter int DATA_WIDTH        = DATA_W,
    parameter int RESULT_WIDTH      = RESULT_W,
    parameter int INSTRUCTION_WIDTH = DATA_WIDTH + ADDR_WIDTH + OPCODE_WIDTH
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         finished,
    output logic [RESULT_WIDTH-1:0]      result,
    output logic                         illegal_op,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    state_t                       state_q, state_n;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_n;
    logic [RESULT_WIDTH-1:0]      result_q, result_n;
    logic                         illegal_q, illegal_n;
    logic [ADDR_WIDTH-1:0]        clr_q, clr_n;
    logic                         rd_valid_q;

    logic [OPCODE_WIDTH-1:0] op_field;
    logic [ADDR_WIDTH-1:0]   addr_field;
    logic [DATA_WIDTH-1:0]   data_field;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] ram_b_rdata;

    assign op_field   = instr_q[OPCODE_WIDTH-1:0];
    assign addr_field = instr_q[OPCODE_WIDTH +: ADDR_WIDTH];
    assign data_field = instr_q[INSTRUCTION_WIDTH-1 -: DATA_WIDTH];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
            clr_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            instr_q    <= instr_n;
            result_q   <= result_n;
            illegal_q  <= illegal_n;
            clr_q      <= clr_n;
            rd_valid_q <= 1'b1;
        end
    end

    // DONE waits for start to drop so a held start executes only once.
    always_comb begin
        state_n   = state_q;
        instr_n   = instr_q;
        result_n  = result_q;
        illegal_n = illegal_q;
        clr_n     = clr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_n = instruction;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                illegal_n = 1'b0;
                if (op_field == OPCODE_WIDTH'(OP_NOP)) begin
                    result_n = '0;
                    state_n  = S_DONE;
                end else if (op_field == OPCODE_WIDTH'(OP_MEMWRITE)) begin
                    result_n = RESULT_WIDTH'(data_field);
                    state_n  = S_DONE;
                end else if (op_field == OPCODE_WIDTH'(OP_MEMREAD)) begin
                    state_n = S_READ_WAIT;
                end else if (op_field == OPCODE_WIDTH'(OP_MEMCLEAR)) begin
                    clr_n   = '0;
                    state_n = S_CLEAR;
                end else begin
                    result_n  = '0;
                    illegal_n = 1'b1;
                    state_n   = S_DONE;
                end
            end
            S_READ_WAIT: begin
                result_n = RESULT_WIDTH'(ram_rdata);
                state_n  = S_DONE;
            end
            S_CLEAR: begin
                if (clr_q == {ADDR_WIDTH{1'b1}}) begin
                    result_n = '0;
                    state_n  = S_DONE;
                end else begin
                    clr_n = clr_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Write enable comes straight from state so an async reset halts writes at once.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_field;
        ram_wdata = data_field;
        if (state_q == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_q;
            ram_wdata = '0;
        end else if (state_q == S_EXEC && op_field == OPCODE_WIDTH'(OP_MEMWRITE)) begin
            ram_we = 1'b1;
        end
    end

    dp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock   (clock),
        .a_we    (ram_we),
        .a_addr  (ram_addr),
        .a_wdata (ram_wdata),
        .a_rdata (ram_rdata),
        .b_addr  (rd_addr),
        .b_rdata (ram_b_rdata)
    );

    // The RAM read register has no reset, so mask it until the first edge after reset.
    assign rd_data    = rd_valid_q ? ram_b_rdata : '0;
    assign finished   = (state_q == S_IDLE);
    assign result     = result_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_datapath_exec.sv
// Scoreboard bench for datapath_exec: stimulus queues expected results, a monitor
// checks them whenever finished rises; latency and renderer reads checked inline.
module tb_datapath_exec;

    localparam int DEPTH = 256;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [27:0] instruction;
    logic        finished;
    logic [15:0] result;
    logic        illegal_op;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;

    int pass_count = 0;
    int total_count = 0;

    logic [15:0] sb_result[$];
    logic        sb_illegal[$];
    logic        prev_finished = 1'b1;
    logic        mon_skip = 1'b0;

    datapath_exec dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .instruction (instruction),
        .finished    (finished),
        .result      (result),
        .illegal_op  (illegal_op),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A rising finished means a result is presented; match it against the oldest expectation.
    always @(posedge clock) begin
        #1;
        if (finished && !prev_finished) begin
            if (mon_skip) begin
                mon_skip = 1'b0;
            end else if (sb_result.size() == 0) begin
                check_output("unexpected_completion", 32'd1, 32'd0);
            end else begin
                check_output("result", 32'(result), 32'(sb_result.pop_front()));
                check_output("illegal_op", 32'(illegal_op), 32'(sb_illegal.pop_front()));
            end
        end
        prev_finished = finished;
    end

    task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] addr, input logic [15:0] data,
                                  input int hold, input int exp_latency,
                                  input logic [15:0] exp_result, input logic exp_illegal);
        int edges;
        sb_result.push_back(exp_result);
        sb_illegal.push_back(exp_illegal);
        @(negedge clock);
        instruction = {data, addr, op};
        start = 1'b1;
        edges = 0;
        while (1) begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == hold) start = 1'b0;
            if (edges == 1) check_output("finished_drop", 32'(finished), 32'd0);
            if (edges > 1 && finished) break;
            if (edges > exp_latency + 20) break;
        end
        start = 1'b0;
        check_output("latency", 32'(edges), 32'(exp_latency));
    endtask

    task automatic check_rd(input logic [7:0] addr, input logic [15:0] expected);
        @(negedge clock);
        rd_addr = addr;
        @(posedge clock);
        #1;
        check_output("rd_data", 32'(rd_data), 32'(expected));
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        instruction = '0;
        rd_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_finished", 32'(finished), 32'd1);
        check_output("reset_result", 32'(result), 32'd0);
        check_output("reset_illegal", 32'(illegal_op), 32'd0);
        check_output("reset_rd_data", 32'(rd_data), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        $display("[TB] write then read back");
        apply_stimulus(4'h2, 8'd5, 16'h1234, 2, 3, 16'h1234, 1'b0);
        check_rd(8'd5, 16'h1234);
        apply_stimulus(4'h1, 8'd5, 16'h0000, 2, 4, 16'h1234, 1'b0);

        $display("[TB] illegal opcode with long start");
        apply_stimulus(4'hF, 8'd5, 16'hFFFF, 5, 6, 16'h0000, 1'b1);
        apply_stimulus(4'h0, 8'd0, 16'h9999, 2, 3, 16'h0000, 1'b0);

        $display("[TB] memory clear");
        apply_stimulus(4'h2, 8'd0, 16'h1111, 2, 3, 16'h1111, 1'b0);
        apply_stimulus(4'h2, 8'd255, 16'h2222, 2, 3, 16'h2222, 1'b0);
        check_rd(8'd255, 16'h2222);
        apply_stimulus(4'h3, 8'd0, 16'h0000, 2, DEPTH + 3, 16'h0000, 1'b0);
        check_rd(8'd0, 16'h0000);
        check_rd(8'd255, 16'h0000);
        apply_stimulus(4'h1, 8'd9, 16'h0000, 2, 4, 16'h0000, 1'b0);

        $display("[TB] reset during clear");
        apply_stimulus(4'h2, 8'd200, 16'hBEEF, 2, 3, 16'hBEEF, 1'b0);
        apply_stimulus(4'h2, 8'd50, 16'h0050, 2, 3, 16'h0050, 1'b0);
        apply_stimulus(4'h2, 8'd100, 16'h0100, 2, 3, 16'h0100, 1'b0);
        @(negedge clock);
        instruction = {16'h0000, 8'd0, 4'h3};
        start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clock);
        #2;
        mon_skip = 1'b1;
        resetn = 1'b0;
        #1;
        check_output("abort_finished", 32'(finished), 32'd1);
        check_output("abort_result", 32'(result), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        check_rd(8'd200, 16'hBEEF);
        check_rd(8'd50, 16'h0000);
        check_rd(8'd100, 16'h0100);

        $display("[TB] read-before-write on renderer port");
        apply_stimulus(4'h2, 8'd7, 16'h5555, 2, 3, 16'h5555, 1'b0);
        sb_result.push_back(16'hAAAA);
        sb_illegal.push_back(1'b0);
        @(negedge clock);
        rd_addr = 8'd7;
        instruction = {16'hAAAA, 8'd7, 4'h2};
        start = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_output("rbw_old", 32'(rd_data), 32'h5555);
        @(posedge clock);
        #1;
        check_output("rbw_new", 32'(rd_data), 32'hAAAA);
        repeat (3) @(posedge clock);
        #2;
        check_output("sb_drain", 32'(sb_result.size()), 32'd0);

        $display("[TB] %0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
